mc8051_agu: RTL and testbench
=============================

Name: mc8051_agu

Overview:
- Registered, handshaked address generation unit for the mc8051 core.
- Replaces the per-stage combinational address selects with a single parametrised engine. The engine captures the operand sources on request and computes the base address for the selected addressing mode.
- It then emits 1..MAX_BURST consecutive addresses over a valid/ready interface.
- Multi-byte fetches (LCALL/LJMP operands, MOVX bursts, stack pushes) use one request instead of per-stage muxing.

Parameters:
- ADDR_W, 16, width of emitted address; byte-space modes zero-extend into it.
- BL_W, 3, width of burst-length field.
- MAX_BURST, 4, largest legal burst length; requests above it are clamped to MAX_BURST.

Ports:
- i_mcu_clk  in  1  core clock
- i_mcu_resetn  in  1  asynchronous active-low reset
- i_req_valid  in  1  request strobe
- o_req_ready  out  1  high only in IDLE
- i_mode  in  4  addressing mode (see Behaviour)
- i_burst_len  in  BL_W  beat count; 0 treated as 1
- i_flush  in  1  synchronous abort
- i_pch, i_pcl, i_dph, i_dpl, i_acc, i_sp, i_psw, i_sx_0, i_s1_instr_buffer, i_s2_data_buffer, i_s3_data_buffer  in  8 each  operand sources
- o_addr  out  ADDR_W  current beat address
- o_addr_valid  out  1  beat valid
- i_addr_ready  in  1  consumer accepts beat
- o_addr_last  out  1  final beat of burst
- o_bit_idx  out  3  bit position (BIT mode), else 0
- o_is_sfr  out  1  BIT mode address ≥0x80
- o_mode_err  out  1  one-cycle pulse on reserved mode

Behaviour:
- Clocking and reset:
  - Single clock domain.
  - Reset is asynchronous and active-low.
  - All registers clear on reset: state=IDLE, o_addr=0, o_addr_valid=0, o_addr_last=0, o_bit_idx=0, o_is_sfr=0, o_mode_err=0. o_req_ready=1 after reset.
- Request acceptance:
  - A request is accepted when i_req_valid & o_req_ready.
  - All sources, mode and length are sampled at acceptance; later source changes have no effect.
- Base address by mode, where RB = {i_psw[4:3],3'b0}:
  - 0 RS_N: RB + instr[2:0]
  - 1 RS_I: RB + instr[0]
  - 2 PC: {pch,pcl}
  - 3 INDX16: {s3b,s2b}
  - 4 INDX8: s2b
  - 5 SINDX8: s3b
  - 6 DPTR: {dph,dpl}
  - 7 DPTR+A: {dph,dpl} + acc
  - 8 PC+A: {pch,pcl} + acc
  - 9 BIT:
    - s2b[7]=0: 0x20 + s2b[6:3], o_is_sfr=0
    - s2b[7]=1: {s2b[7:3],3'b000}, o_is_sfr=1
    - o_bit_idx = s2b[2:0]
  - 10 SX: sx_0
  - 11 SP: sp
  - 12 SP_INC: sp+1
  - 13 SP_DEC: sp-1
  - 14-15 reserved: request is accepted, no beats are issued, o_mode_err pulses the cycle after acceptance, and the FSM stays IDLE.
- Byte-space modes (0,1,4,5,9,10-13) zero-extend to ADDR_W.
- 16-bit sums wrap modulo 2^ADDR_W.
- Beat address = base + beat_idx:
  - Byte-space modes wrap within 8 bits (0xFF → 0x00, upper bits stay 0).
  - 16-bit modes wrap at 2^ADDR_W.
  - BIT and SP_DEC force burst length 1.
- Latency: first beat registered, so o_addr_valid=1 in the cycle after acceptance.
- FSM:
  - IDLE: on accept (non-reserved mode) → BURST, beat_idx=0, remaining=len-1.
  - BURST:
    - o_addr_valid=1.
    - On i_addr_ready: if remaining=0 → IDLE, valid drops next cycle; else beat_idx+1, remaining-1, address updates next cycle.
    - While valid & !ready: o_addr, o_addr_last, o_bit_idx and o_is_sfr hold stable.
    - o_addr_last=1 exactly when remaining=0.
- No back-to-back accept: o_req_ready stays 0 in the cycle the last beat is consumed, giving a 1-cycle bubble minimum.
- i_flush:
  - In any state → IDLE next cycle, o_addr_valid=0, o_addr_last=0.
  - Flush wins over a simultaneous i_req_valid or i_addr_ready; the beat is not counted as consumed.
- Reset asserted mid-burst: outputs clear immediately (async); no beat is issued after deassertion until a new request.

Test Plan:
- Reset mid-burst: DPTR mode, dph=0x12, dpl=0x34, len=3, stall ready; assert resetn=0 → o_addr_valid, o_addr and o_addr_last are 0 without waiting for a clock edge; o_req_ready=1 after release.
- PC burst with wrap: pch=0xFF, pcl=0xFE, len=4, ready=1 → addresses 0xFFFE, 0xFFFF, 0x0000, 0x0001, last on 4th; valid first seen 1 cycle after accept.
- Register bank: psw=0x18, instr=0xEF, mode RS_N → 0x001F. Mode RS_I with instr=0xE7 → 0x0019.
- BIT decode:
  - s2b=0x2D → addr 0x0025, bit_idx=5, is_sfr=0.
  - s2b=0xE3 → addr 0x00E0, bit_idx=3, is_sfr=1.
  - len=3 is forced to 1 beat.
- Backpressure and byte wrap: SX mode, sx_0=0xFE, len=3, ready low 2 cycles on beat 1 → address held at 0x00FE, then 0x00FF, then 0x0000; later source changes are ignored.
- Flush and reserved mode:
  - Flush on beat 2 of a 4-beat burst with ready=1 → valid=0 next cycle, then a new request is accepted.
  - Mode 15 → o_mode_err pulses 1 cycle, no valid beats.

Source files
------------

// File: rtl/mc8051_agu_if.sv
// Request/beat bundle between the mc8051 pipeline and its address generation unit.
// master = pipeline side, slave = AGU side.
interface mc8051_agu_if #(
  parameter int ADDR_W = 16,
  parameter int BL_W   = 3
);
  logic              i_req_valid;
  logic              o_req_ready;
  logic [3:0]        i_mode;
  logic [BL_W-1:0]   i_burst_len;
  logic              i_flush;
  logic [7:0]        i_pch;
  logic [7:0]        i_pcl;
  logic [7:0]        i_dph;
  logic [7:0]        i_dpl;
  logic [7:0]        i_acc;
  logic [7:0]        i_sp;
  logic [7:0]        i_psw;
  logic [7:0]        i_sx_0;
  logic [7:0]        i_s1_instr_buffer;
  logic [7:0]        i_s2_data_buffer;
  logic [7:0]        i_s3_data_buffer;
  logic [ADDR_W-1:0] o_addr;
  logic              o_addr_valid;
  logic              i_addr_ready;
  logic              o_addr_last;
  logic [2:0]        o_bit_idx;
  logic              o_is_sfr;
  logic              o_mode_err;

  modport master (
    output i_req_valid, i_mode, i_burst_len, i_flush,
           i_pch, i_pcl, i_dph, i_dpl, i_acc, i_sp, i_psw, i_sx_0,
           i_s1_instr_buffer, i_s2_data_buffer, i_s3_data_buffer, i_addr_ready,
    input  o_req_ready, o_addr, o_addr_valid, o_addr_last, o_bit_idx, o_is_sfr, o_mode_err
  );

  modport slave (
    input  i_req_valid, i_mode, i_burst_len, i_flush,
           i_pch, i_pcl, i_dph, i_dpl, i_acc, i_sp, i_psw, i_sx_0,
           i_s1_instr_buffer, i_s2_data_buffer, i_s3_data_buffer, i_addr_ready,
    output o_req_ready, o_addr, o_addr_valid, o_addr_last, o_bit_idx, o_is_sfr, o_mode_err
  );
endinterface

// File: rtl/mc8051_agu.sv
// Address generation unit: samples operand sources on request, computes the mode's
// base address and streams 1..MAX_BURST consecutive beat addresses.
//
//   state   | meaning
//   S_IDLE  | waiting for a request, o_req_ready high
//   S_BURST | presenting beats, o_addr_valid high
module mc8051_agu #(
  parameter int ADDR_W    = 16,
  parameter int BL_W      = 3,
  parameter int MAX_BURST = 4
) (
  input logic         i_mcu_clk,
  input logic         i_mcu_resetn,
  mc8051_agu_if.slave agu
);

  typedef enum logic {S_IDLE, S_BURST} state_t;

  state_t            state, state_nxt;
  logic              accept, reserved, burst_start, beat_take;
  logic              byte_mode_d, byte_mode_q;
  logic [BL_W-1:0]   len_eff, remaining_q;
  logic [7:0]        rb, byte_base, byte_inc;
  logic [15:0]       wide_base;
  logic [ADDR_W-1:0] base_addr, addr_inc;
  logic [2:0]        bit_idx_d;
  logic              is_sfr_d;
  logic              unused_bits;

  assign unused_bits = ^{agu.i_psw[7:5], agu.i_psw[2:0], agu.i_s1_instr_buffer[7:3]};

  assign reserved    = (agu.i_mode >= 4'd14);
  assign accept      = agu.i_req_valid & agu.o_req_ready & ~agu.i_flush;
  assign burst_start = accept & ~reserved;
  assign beat_take   = (state == S_BURST) & agu.i_addr_ready & ~agu.i_flush;

  always_comb begin
    rb          = {1'b0, agu.i_psw[4:3], 5'b0} >> 2;
    byte_base   = 8'h00;
    wide_base   = 16'h0000;
    byte_mode_d = 1'b1;
    bit_idx_d   = 3'd0;
    is_sfr_d    = 1'b0;
    case (agu.i_mode)
      4'd0: byte_base = rb + {5'b0, agu.i_s1_instr_buffer[2:0]};
      4'd1: byte_base = rb + {7'b0, agu.i_s1_instr_buffer[0]};
      4'd2: begin byte_mode_d = 1'b0; wide_base = {agu.i_pch, agu.i_pcl}; end
      4'd3: begin byte_mode_d = 1'b0; wide_base = {agu.i_s3_data_buffer, agu.i_s2_data_buffer}; end
      4'd4: byte_base = agu.i_s2_data_buffer;
      4'd5: byte_base = agu.i_s3_data_buffer;
      4'd6: begin byte_mode_d = 1'b0; wide_base = {agu.i_dph, agu.i_dpl}; end
      4'd7: begin byte_mode_d = 1'b0; wide_base = {agu.i_dph, agu.i_dpl} + {8'h00, agu.i_acc}; end
      4'd8: begin byte_mode_d = 1'b0; wide_base = {agu.i_pch, agu.i_pcl} + {8'h00, agu.i_acc}; end
      4'd9: begin
        // Bit-addressable RAM lives at 0x20..0x2F; SFR bits map onto 8-aligned SFRs.
        bit_idx_d = agu.i_s2_data_buffer[2:0];
        is_sfr_d  = agu.i_s2_data_buffer[7];
        byte_base = agu.i_s2_data_buffer[7] ? {agu.i_s2_data_buffer[7:3], 3'b000}
                                            : 8'h20 + {4'h0, agu.i_s2_data_buffer[6:3]};
      end
      4'd10: byte_base = agu.i_sx_0;
      4'd11: byte_base = agu.i_sp;
      4'd12: byte_base = agu.i_sp + 8'd1;
      4'd13: byte_base = agu.i_sp - 8'd1;
      default: ;
    endcase
    base_addr = byte_mode_d ? ADDR_W'(byte_base) : ADDR_W'(wide_base);
  end

  always_comb begin
    len_eff = agu.i_burst_len;
    if (len_eff == '0)
      len_eff = BL_W'(1);
    else if (len_eff > BL_W'(MAX_BURST))
      len_eff = BL_W'(MAX_BURST);
    if (agu.i_mode == 4'd9 || agu.i_mode == 4'd13)
      len_eff = BL_W'(1);
  end

  // Byte-space bursts wrap inside the 8-bit space, upper address bits stay zero.
  assign byte_inc = agu.o_addr[7:0] + 8'd1;
  assign addr_inc = byte_mode_q ? ADDR_W'(byte_inc) : agu.o_addr + ADDR_W'(1);

  always_ff @(posedge i_mcu_clk or negedge i_mcu_resetn) begin
    if (!i_mcu_resetn)
      state <= S_IDLE;
    else
      state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    if (agu.i_flush)
      state_nxt = S_IDLE;
    else begin
      case (state)
        S_IDLE:  if (burst_start) state_nxt = S_BURST;
        S_BURST: if (beat_take && remaining_q == '0) state_nxt = S_IDLE;
        default: state_nxt = S_IDLE;
      endcase
    end
  end

  always_comb begin
    agu.o_req_ready  = (state == S_IDLE);
    agu.o_addr_valid = (state == S_BURST);
  end

  always_ff @(posedge i_mcu_clk or negedge i_mcu_resetn) begin
    if (!i_mcu_resetn) begin
      agu.o_addr      <= '0;
      agu.o_addr_last <= 1'b0;
      agu.o_bit_idx   <= 3'd0;
      agu.o_is_sfr    <= 1'b0;
      agu.o_mode_err  <= 1'b0;
      byte_mode_q     <= 1'b0;
      remaining_q     <= '0;
    end else begin
      agu.o_mode_err <= accept & reserved;
      if (agu.i_flush) begin
        agu.o_addr_last <= 1'b0;
      end else if (burst_start) begin
        agu.o_addr      <= base_addr;
        agu.o_addr_last <= (len_eff == BL_W'(1));
        agu.o_bit_idx   <= bit_idx_d;
        agu.o_is_sfr    <= is_sfr_d;
        byte_mode_q     <= byte_mode_d;
        remaining_q     <= len_eff - BL_W'(1);
      end else if (beat_take) begin
        if (remaining_q == '0) begin
          agu.o_addr_last <= 1'b0;
        end else begin
          agu.o_addr      <= addr_inc;
          agu.o_addr_last <= (remaining_q == BL_W'(1));
          remaining_q     <= remaining_q - BL_W'(1);
        end
      end
    end
  end

endmodule

// File: tb/tb_mc8051_agu.sv
// Self-checking bench for mc8051_agu: table of addressing-mode vectors plus
// hand-written backpressure, flush, reserved-mode and async-reset sequences.
`timescale 1ns/1ps
module tb_mc8051_agu;
  localparam int ADDR_W    = 16;
  localparam int BL_W      = 3;
  localparam int MAX_BURST = 4;

  typedef struct {
    logic [15:0] addr;
    logic        last;
    logic [2:0]  bit_idx;
    logic        is_sfr;
  } beat_t;

  typedef struct {
    logic [3:0]  mode;
    logic [2:0]  len;
    logic [7:0]  pch, pcl, dph, dpl, acc, sp, psw, sx, s1, s2, s3;
    logic [15:0] first;
    int          n;
    logic        byte_m;
    logic [2:0]  bit_idx;
    logic        is_sfr;
  } vec_t;

  logic clk = 1'b0;
  logic rst_n = 1'b1;
  int   checks = 0;
  int   errors = 0;
  beat_t exp_q[$];
  vec_t  vt[16];

  always #5 clk = ~clk;

  mc8051_agu_if #(.ADDR_W(ADDR_W), .BL_W(BL_W)) agu ();

  mc8051_agu #(.ADDR_W(ADDR_W), .BL_W(BL_W), .MAX_BURST(MAX_BURST)) dut (
    .i_mcu_clk   (clk),
    .i_mcu_resetn(rst_n),
    .agu         (agu)
  );

  function automatic vec_t mk(input logic [3:0] mode, input logic [2:0] len,
                              input logic [7:0] pch, pcl, dph, dpl, acc, sp, psw, sx, s1, s2, s3,
                              input logic [15:0] first, input int n, input logic byte_m,
                              input logic [2:0] bit_idx, input logic is_sfr);
    vec_t v;
    v.mode = mode; v.len = len;
    v.pch = pch; v.pcl = pcl; v.dph = dph; v.dpl = dpl; v.acc = acc; v.sp = sp;
    v.psw = psw; v.sx = sx; v.s1 = s1; v.s2 = s2; v.s3 = s3;
    v.first = first; v.n = n; v.byte_m = byte_m; v.bit_idx = bit_idx; v.is_sfr = is_sfr;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h expected=%h", name, got, exp);
    end
  endtask

  task automatic push_beats(input vec_t v);
    beat_t b;
    for (int k = 0; k < v.n; k++) begin
      b.addr    = v.byte_m ? {8'h00, v.first[7:0] + 8'(k)} : v.first + 16'(k);
      b.last    = (k == v.n - 1);
      b.bit_idx = v.bit_idx;
      b.is_sfr  = v.is_sfr;
      exp_q.push_back(b);
    end
  endtask

  // Inspects the handshake the next posedge will see, then advances to the next negedge.
  task automatic tick();
    beat_t e;
    if (agu.o_addr_valid && agu.i_addr_ready && !agu.i_flush) begin
      chk("req_ready_busy", 32'(agu.o_req_ready), 32'd0);
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_beat got addr=%h last=%b", agu.o_addr, agu.o_addr_last);
      end else begin
        e = exp_q.pop_front();
        if (agu.o_addr !== e.addr || agu.o_addr_last !== e.last ||
            agu.o_bit_idx !== e.bit_idx || agu.o_is_sfr !== e.is_sfr) begin
          errors++;
          $display("FAIL beat got addr=%h last=%b bit=%0d sfr=%b expected addr=%h last=%b bit=%0d sfr=%b",
                   agu.o_addr, agu.o_addr_last, agu.o_bit_idx, agu.o_is_sfr,
                   e.addr, e.last, e.bit_idx, e.is_sfr);
        end
      end
    end
    @(negedge clk);
  endtask

  task automatic drive_req(input vec_t v);
    agu.i_mode = v.mode; agu.i_burst_len = v.len;
    agu.i_pch = v.pch; agu.i_pcl = v.pcl; agu.i_dph = v.dph; agu.i_dpl = v.dpl;
    agu.i_acc = v.acc; agu.i_sp = v.sp; agu.i_psw = v.psw; agu.i_sx_0 = v.sx;
    agu.i_s1_instr_buffer = v.s1; agu.i_s2_data_buffer = v.s2; agu.i_s3_data_buffer = v.s3;
    chk("req_ready_idle", 32'(agu.o_req_ready), 32'd1);
    agu.i_req_valid = 1'b1;
    tick();
    agu.i_req_valid = 1'b0;
  endtask

  task automatic scramble();
    agu.i_pch = 8'($urandom); agu.i_pcl = 8'($urandom); agu.i_dph = 8'($urandom);
    agu.i_dpl = 8'($urandom); agu.i_acc = 8'($urandom); agu.i_sp = 8'($urandom);
    agu.i_psw = 8'($urandom); agu.i_sx_0 = 8'($urandom); agu.i_mode = 4'($urandom);
    agu.i_burst_len = 3'($urandom); agu.i_s1_instr_buffer = 8'($urandom);
    agu.i_s2_data_buffer = 8'($urandom); agu.i_s3_data_buffer = 8'($urandom);
  endtask

  task automatic drain();
    agu.i_addr_ready = 1'b1;
    for (int i = 0; i < 20 && exp_q.size() != 0; i++) tick();
    chk("drain_left", 32'(exp_q.size()), 32'd0);
    exp_q.delete();
    chk("idle_after_burst", 32'(agu.o_addr_valid), 32'd0);
  endtask

  task automatic run_vector(input vec_t v);
    push_beats(v);
    agu.i_addr_ready = 1'b1;
    drive_req(v);
    chk("first_valid_latency", 32'(agu.o_addr_valid), 32'd1);
    scramble();
    drain();
    tick();
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout");
    $fatal(1, "timeout");
  end

  initial begin
    vec_t v;
    agu.i_req_valid = 0; agu.i_mode = 0; agu.i_burst_len = 0; agu.i_flush = 0;
    agu.i_addr_ready = 0; agu.i_pch = 0; agu.i_pcl = 0; agu.i_dph = 0; agu.i_dpl = 0;
    agu.i_acc = 0; agu.i_sp = 0; agu.i_psw = 0; agu.i_sx_0 = 0;
    agu.i_s1_instr_buffer = 0; agu.i_s2_data_buffer = 0; agu.i_s3_data_buffer = 0;

    //            mode   len   pch    pcl    dph    dpl    acc    sp     psw    sx     s1     s2     s3     first     n  byte bit  sfr
    vt[0]  = mk(4'd2,  3'd4, 8'hFF, 8'hFE, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 16'hFFFE, 4, 0, 3'd0, 0);
    vt[1]  = mk(4'd0,  3'd1, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h18, 8'h00, 8'hEF, 8'h00, 8'h00, 16'h001F, 1, 1, 3'd0, 0);
    vt[2]  = mk(4'd1,  3'd1, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h18, 8'h00, 8'hE7, 8'h00, 8'h00, 16'h0019, 1, 1, 3'd0, 0);
    vt[3]  = mk(4'd9,  3'd3, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h2D, 8'h00, 16'h0025, 1, 1, 3'd5, 0);
    vt[4]  = mk(4'd9,  3'd1, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'hE3, 8'h00, 16'h00E0, 1, 1, 3'd3, 1);
    vt[5]  = mk(4'd3,  3'd2, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h34, 8'h12, 16'h1234, 2, 0, 3'd0, 0);
    vt[6]  = mk(4'd4,  3'd2, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'hFF, 8'h00, 16'h00FF, 2, 1, 3'd0, 0);
    vt[7]  = mk(4'd5,  3'd0, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h80, 16'h0080, 1, 1, 3'd0, 0);
    vt[8]  = mk(4'd6,  3'd7, 8'h00, 8'h00, 8'hAB, 8'hCD, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 16'hABCD, 4, 0, 3'd0, 0);
    vt[9]  = mk(4'd7,  3'd1, 8'h00, 8'h00, 8'h12, 8'hF0, 8'h20, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 16'h1310, 1, 0, 3'd0, 0);
    vt[10] = mk(4'd8,  3'd2, 8'hFF, 8'hF0, 8'h00, 8'h00, 8'h20, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 16'h0010, 2, 0, 3'd0, 0);
    vt[11] = mk(4'd10, 3'd1, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h7F, 8'h00, 8'h00, 8'h00, 16'h007F, 1, 1, 3'd0, 0);
    vt[12] = mk(4'd11, 3'd2, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h07, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 16'h0007, 2, 1, 3'd0, 0);
    vt[13] = mk(4'd12, 3'd2, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'hFF, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 16'h0000, 2, 1, 3'd0, 0);
    vt[14] = mk(4'd13, 3'd3, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 16'h00FF, 1, 1, 3'd0, 0);
    vt[15] = mk(4'd0,  3'd4, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h05, 8'h00, 8'h00, 16'h0005, 4, 1, 3'd0, 0);

    #1 rst_n = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst_valid", 32'(agu.o_addr_valid), 32'd0);
    chk("rst_ready", 32'(agu.o_req_ready), 32'd1);
    chk("rst_addr", 32'(agu.o_addr), 32'd0);
    chk("rst_last", 32'(agu.o_addr_last), 32'd0);
    chk("rst_bit_sfr_err", 32'({agu.o_bit_idx, agu.o_is_sfr, agu.o_mode_err}), 32'd0);
    rst_n = 1'b1;
    @(negedge clk);

    for (int i = 0; i < 16; i++) run_vector(vt[i]);

    // Backpressure on beat 1, byte-space wrap, sources changed after accept.
    v = mk(4'd10, 3'd3, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'hFE, 8'h00, 8'h00, 8'h00, 16'h00FE, 3, 1, 3'd0, 0);
    push_beats(v);
    agu.i_addr_ready = 1'b0;
    drive_req(v);
    agu.i_sx_0 = 8'h11;
    for (int i = 0; i < 2; i++) begin
      chk("stall_valid", 32'(agu.o_addr_valid), 32'd1);
      chk("stall_addr_held", 32'(agu.o_addr), 32'h00FE);
      chk("stall_last_held", 32'(agu.o_addr_last), 32'd0);
      tick();
    end
    drain();
    tick();

    // Flush while beat 2 of a 4-beat burst is presented.
    v = mk(4'd6, 3'd4, 8'h00, 8'h00, 8'h40, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 16'h4000, 4, 0, 3'd0, 0);
    push_beats(v);
    agu.i_addr_ready = 1'b1;
    drive_req(v);
    tick();
    chk("flush_beat2_addr", 32'(agu.o_addr), 32'h4001);
    agu.i_flush = 1'b1;
    tick();
    agu.i_flush = 1'b0;
    exp_q.delete();
    chk("flush_valid", 32'(agu.o_addr_valid), 32'd0);
    chk("flush_last", 32'(agu.o_addr_last), 32'd0);
    chk("flush_ready", 32'(agu.o_req_ready), 32'd1);
    run_vector(mk(4'd10, 3'd1, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h33, 8'h00, 8'h00, 8'h00, 16'h0033, 1, 1, 3'd0, 0));

    // Reserved mode: single error pulse, no beats.
    v = mk(4'd15, 3'd2, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 16'h0000, 0, 0, 3'd0, 0);
    chk("pre_mode_err", 32'(agu.o_mode_err), 32'd0);
    drive_req(v);
    chk("mode_err_pulse", 32'(agu.o_mode_err), 32'd1);
    chk("mode_err_no_valid", 32'(agu.o_addr_valid), 32'd0);
    tick();
    chk("mode_err_clear", 32'(agu.o_mode_err), 32'd0);
    chk("mode_err_idle_valid", 32'(agu.o_addr_valid), 32'd0);
    chk("mode_err_idle_ready", 32'(agu.o_req_ready), 32'd1);

    // Asynchronous reset in the middle of a stalled burst.
    v = mk(4'd6, 3'd3, 8'h00, 8'h00, 8'h12, 8'h34, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 16'h1234, 3, 0, 3'd0, 0);
    agu.i_addr_ready = 1'b0;
    drive_req(v);
    chk("prerst_valid", 32'(agu.o_addr_valid), 32'd1);
    chk("prerst_addr", 32'(agu.o_addr), 32'h1234);
    #2 rst_n = 1'b0;
    #1;
    chk("async_rst_valid", 32'(agu.o_addr_valid), 32'd0);
    chk("async_rst_addr", 32'(agu.o_addr), 32'd0);
    chk("async_rst_last", 32'(agu.o_addr_last), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    agu.i_addr_ready = 1'b1;
    chk("postrst_ready", 32'(agu.o_req_ready), 32'd1);
    tick();
    tick();
    chk("postrst_no_beat", 32'(agu.o_addr_valid), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
